score_writer: RTL
=================

SCORE_WRITER -- requirements
Module: score_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 13'h1148, the SRAM address of the most-significant score digit.
REQ-002 SHALL have parameter CONV_STEPS, default 20, the number of double-dabble shift steps (equal to the score width).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port score  input  20  binary score value.
REQ-006 SHALL have port update  input  1  write request, sampled on each rising edge.
REQ-007 SHALL have port busy  output  1  high while a request is latched, converting or writing.
REQ-008 SHALL have port done  output  1  one-cycle pulse when the last digit write completes.
REQ-009 SHALL have port drv_start  output  1  start request to the downstream sram_driver.
REQ-010 SHALL have port drv_re  output  1  read enable to sram_driver; constant 0.
REQ-011 SHALL have port drv_address  output  13  digit address to sram_driver.
REQ-012 SHALL have port drv_data_write  output  8  digit data to sram_driver.
REQ-013 SHALL have port drv_ready  input  1  ready flag from sram_driver.

Function
REQ-014 SHALL implement the states IDLE, CONVERT, REQ, ACK and WAITRDY.
REQ-015 SHALL, in IDLE on a sampled update=1, latch score saturated to 999999 (any input >999999 becomes 999999), clear the BCD register, set busy=1 at that edge and enter CONVERT.
REQ-016 SHALL in CONVERT perform one double-dabble step per cycle (add 3 to each BCD nibble >=5, then shift left by one bit) for exactly CONV_STEPS cycles, then enter REQ.
REQ-017 SHALL produce six BCD digits, d5 (hundred-thousands) down to d0 (units), each in the range 0-9.
REQ-018 SHALL write digit d(5-i) to address BASE_ADDR+i for i=0..5, in ascending address order.
REQ-019 SHALL drive drv_data_write = {4'h0, digit}.
REQ-020 SHALL, in REQ, when drv_ready=1, register drv_start=1 with drv_address and drv_data_write valid, and enter ACK.
REQ-021 SHALL, in REQ, when drv_ready=0, hold drv_start=0.
REQ-022 SHALL, in ACK, hold drv_start=1 and keep drv_address and drv_data_write stable until drv_ready=0 is sampled, then clear drv_start and enter WAITRDY.
REQ-023 SHALL, in WAITRDY on drv_ready=1, advance the digit index: to REQ if digits remain.
REQ-024 SHALL, in WAITRDY on drv_ready=1 after the 6th digit, pulse done for one cycle and enter IDLE (or CONVERT if a pending request exists).
REQ-025 SHALL, for update=1 sampled while busy, latch score into a pending register (the latest value wins) and set a pending flag.
REQ-026 SHALL, on completing a sequence with the pending flag set, load the pending score, clear the flag, keep busy=1 and enter CONVERT without passing through IDLE.
REQ-027 SHALL, for an update with drv_ready high throughout, raise drv_start exactly 21 rising edges after the edge that sampled update.
REQ-028 SHALL keep drv_address and drv_data_write stable whenever drv_start=1.
REQ-029 SHALL never assert drv_start while drv_ready=0 in state REQ.

Reset
REQ-030 SHALL, on any edge with reset=0, set state IDLE, busy=0, done=0, drv_start=0, drv_re=0, drv_address=BASE_ADDR, drv_data_write=0, clear the pending flag and clear the digit index.
REQ-031 SHALL, when reset=0 arrives mid-conversion or mid-write, abandon the sequence with no further drv_start after that edge, and accept a new update once reset=1.

Verification
REQ-032 SHALL be verified with score=40800, update pulse, sram_driver model WAIT_TIME=3 -> writes 00,04,00,08,00,00 to 0x1148..0x114D in order, one done pulse, then busy=0.
REQ-033 SHALL be verified with score=0 and with score=1048575 -> six writes of 00 and six writes of 09 respectively.
REQ-034 SHALL be verified with score=123456 updated, then updates of 111111 and 222222 issued mid-write -> full 123456 sequence, then exactly one full 222222 sequence, busy high continuously, two done pulses.
REQ-035 SHALL be verified with drv_ready forced low for 10 cycles while in REQ -> drv_start stays 0, then rises on the edge after drv_ready returns to 1.
REQ-036 SHALL be verified with reset=0 pulsed during the 3rd digit write -> next edge busy=0 and drv_start=0, no further writes, and a subsequent update with score=7 -> digits 00,00,00,00,00,07.
REQ-037 SHALL be verified with update held high for 1 cycle and ready high throughout -> first drv_start exactly 21 edges after the update edge.

Source files
------------

// File: rtl/score_writer.sv
// Converts a binary score to six BCD digits (double dabble) and writes them,
// most-significant first, to consecutive SRAM addresses through an sram_driver handshake.
module score_writer #(
   parameter logic [12:0] BASE_ADDR  = 13'h1148,
   parameter int          CONV_STEPS = 20
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [19:0] score,
   input  logic        update,
   output logic        busy,
   output logic        done,
   output logic        drv_start,
   output logic        drv_re,
   output logic [12:0] drv_address,
   output logic [7:0]  drv_data_write,
   input  logic        drv_ready
);

   typedef enum logic [2:0] {IDLE, CONVERT, REQ, ACK, WAITRDY} state_t;

   localparam logic [19:0]   SAT_MAX   = 20'd999999;
   localparam int            CW        = (CONV_STEPS > 1) ? $clog2(CONV_STEPS) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(CONV_STEPS - 1);

   state_t        state_q;
   logic [19:0]   bin_q;
   logic [23:0]   bcd_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]    idx_q;
   logic          pend_q;
   logic [19:0]   pend_score_q;

   logic [19:0]   score_sat_d;
   logic [23:0]   bcd_adj_d;
   logic [23:0]   bcd_d;
   logic [3:0]    digit_d;

   assign drv_re      = 1'b0;
   assign score_sat_d = (score > SAT_MAX) ? SAT_MAX : score;

   // One double-dabble step: correct nibbles >=5, then shift the next binary bit in.
   always_comb begin
      bcd_adj_d = bcd_q;
      for (int i = 0; i < 6; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
      bcd_d = {bcd_adj_d[22:0], bin_q[19]};
   end

   // Index 0 is the most-significant digit, written at BASE_ADDR.
   always_comb begin
      case (idx_q)
         3'd0:    digit_d = bcd_q[23:20];
         3'd1:    digit_d = bcd_q[19:16];
         3'd2:    digit_d = bcd_q[15:12];
         3'd3:    digit_d = bcd_q[11:8];
         3'd4:    digit_d = bcd_q[7:4];
         default: digit_d = bcd_q[3:0];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         busy           <= 1'b0;
         done           <= 1'b0;
         drv_start      <= 1'b0;
         drv_address    <= BASE_ADDR;
         drv_data_write <= 8'h00;
         pend_q         <= 1'b0;
         pend_score_q   <= 20'd0;
         idx_q          <= 3'd0;
         cnt_q          <= '0;
         bin_q          <= 20'd0;
         bcd_q          <= 24'd0;
      end else begin
         done <= 1'b0;
         if (update && state_q != IDLE) begin
            pend_q       <= 1'b1;
            pend_score_q <= score_sat_d;
         end
         case (state_q)
            IDLE: begin
               if (update) begin
                  bin_q   <= score_sat_d;
                  bcd_q   <= 24'd0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= CONVERT;
               end
            end
            CONVERT: begin
               bcd_q <= bcd_d;
               bin_q <= {bin_q[18:0], 1'b0};
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == LAST_STEP) begin
                  idx_q   <= 3'd0;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (drv_ready) begin
                  drv_start      <= 1'b1;
                  drv_address    <= BASE_ADDR + {10'd0, idx_q};
                  drv_data_write <= {4'h0, digit_d};
                  state_q        <= ACK;
               end
            end
            ACK: begin
               if (!drv_ready) begin
                  drv_start <= 1'b0;
                  state_q   <= WAITRDY;
               end
            end
            WAITRDY: begin
               if (drv_ready) begin
                  if (idx_q == 3'd5) begin
                     done  <= 1'b1;
                     idx_q <= 3'd0;
                     // An update arriving on this very edge is newer than the pending one.
                     if (pend_q || update) begin
                        bin_q   <= update ? score_sat_d : pend_score_q;
                        pend_q  <= 1'b0;
                        bcd_q   <= 24'd0;
                        cnt_q   <= '0;
                        state_q <= CONVERT;
                     end else begin
                        busy    <= 1'b0;
                        state_q <= IDLE;
                     end
                  end else begin
                     idx_q   <= idx_q + 3'd1;
                     state_q <= REQ;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
